// File: rtl/int_gen_pkg.sv
// Shared constants for int_gen: register indices, CTRL bit positions and
// interrupt line indices.
package int_gen_pkg;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_C0_LOAD  = 3'd1,
    REG_C1_LOAD  = 3'd2,
    REG_C0_COUNT = 3'd3,
    REG_C1_COUNT = 3'd4,
    REG_STATUS   = 3'd5,
    REG_PRESCALE = 3'd6,
    REG_NONE     = 3'd7
  } reg_idx_e;

  localparam int unsigned CTRL_C0_EN     = 0;
  localparam int unsigned CTRL_C0_AUTO   = 1;
  localparam int unsigned CTRL_C1_EN     = 2;
  localparam int unsigned CTRL_C1_AUTO   = 3;
  localparam int unsigned CTRL_IO_EN_LSB = 4;

  localparam int unsigned IRQ_IO0  = 0;
  localparam int unsigned IRQ_IO1  = 1;
  localparam int unsigned IRQ_CNT0 = 2;
  localparam int unsigned IRQ_CNT1 = 3;

endpackage

// File: rtl/int_counter.sv
// One down-counter: load/count registers, enable/auto-reload control and a
// registered single-cycle terminal pulse.
module int_counter
  import int_gen_pkg::*;
#(
  parameter int unsigned CW = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          tick_i,
  input  logic          load_we_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          ctrl_we_i,
  input  logic          en_i,
  input  logic          auto_i,
  output logic [CW-1:0] load_o,
  output logic [CW-1:0] count_o,
  output logic          en_o,
  output logic          auto_o,
  output logic          pulse_o
);

  logic [CW-1:0] load_q, load_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q, en_d;
  logic          auto_q, auto_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    pulse_d = 1'b0;
    if (ctrl_we_i) begin
      en_d   = en_i;
      auto_d = auto_i;
    end
    if (en_q && tick_i) begin
      if (count_q != '0) begin
        count_d = count_q - CW'(1);
      end else begin
        pulse_d = 1'b1;
        if (auto_q)
          count_d = load_q;
        else if (!ctrl_we_i)
          en_d = 1'b0;
      end
    end
    // A LOAD write overrides any decrement/reload in the same cycle.
    if (load_we_i) begin
      load_d  = load_val_i;
      count_d = load_val_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      pulse_q <= pulse_d;
    end
  end

  assign load_o  = load_q;
  assign count_o = count_q;
  assign en_o    = en_q;
  assign auto_o  = auto_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/int_gen.sv
// Interrupt generator: synchronized IO edge interrupts plus two timer counters.
// Define INT_GEN_PRESCALE_EN to add the PRESCALE register and shared tick divider.
module int_gen
  import int_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    io_irq,
  input  logic          we,
  input  logic [2:0]    addr,
  input  logic [CW-1:0] wdata,
  output logic [CW-1:0] rdata,
  output logic [3:0]    interrupts,
  input  logic [3:0]    interrupt_taken
);

  logic [1:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;
  logic [1:0]             sync_out;
  logic                   vld_out;
  logic [1:0]             prev_q, prev_d;
  logic [1:0]             armed_q, armed_d;
  logic [1:0]             io_pulse_q, io_pulse_d;
  logic [1:0]             io_en_q, io_en_d;
  logic [3:0]             status_q, status_d;
  logic                   tick;

  logic                   wr_ctrl, wr_c0, wr_c1, wr_status;
  logic [CW-1:0]          c0_load, c0_count, c1_load, c1_count;
  logic                   c0_en, c0_auto, c0_pulse, c1_en, c1_auto, c1_pulse;

  assign wr_ctrl   = we && (addr == REG_CTRL);
  assign wr_c0     = we && (addr == REG_C0_LOAD);
  assign wr_c1     = we && (addr == REG_C1_LOAD);
  assign wr_status = we && (addr == REG_STATUS);

  // vld_q marks when the synchronizer holds real post-reset samples, so a line
  // already high at reset release is never mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      vld_q <= '0;
    end else begin
      sync_q[0] <= io_irq;
      vld_q[0]  <= 1'b1;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
        vld_q[s]  <= vld_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign vld_out  = vld_q[SYNC_STAGES-1];

  always_comb begin
    prev_d     = sync_out;
    armed_d    = armed_q | ({2{vld_out}} & ~sync_out);
    io_pulse_d = sync_out & ~prev_q & armed_q & io_en_q;
    io_en_d    = wr_ctrl ? wdata[CTRL_IO_EN_LSB +: 2] : io_en_q;
    status_d   = (status_q & ~(wr_status ? wdata[3:0] : 4'b0000)) | interrupts;
  end

`ifdef INT_GEN_PRESCALE_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] pcnt_q, pcnt_d;

  assign tick = (pcnt_q == prescale_q);

  always_comb begin
    prescale_d = (we && (addr == REG_PRESCALE)) ? wdata[7:0] : prescale_q;
    pcnt_d     = tick ? 8'd0 : pcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      armed_q    <= '0;
      io_pulse_q <= '0;
      io_en_q    <= '0;
      status_q   <= '0;
    end else begin
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      io_pulse_q <= io_pulse_d;
      io_en_q    <= io_en_d;
      status_q   <= status_d;
    end
  end

  int_counter #(.CW(CW)) u_cnt0 (
    .clk_i      (clk),
    .reset_i    (reset),
    .tick_i     (tick),
    .load_we_i  (wr_c0),
    .load_val_i (wdata),
    .ctrl_we_i  (wr_ctrl),
    .en_i       (wdata[CTRL_C0_EN]),
    .auto_i     (wdata[CTRL_C0_AUTO]),
    .load_o     (c0_load),
    .count_o    (c0_count),
    .en_o       (c0_en),
    .auto_o     (c0_auto),
    .pulse_o    (c0_pulse)
  );

  int_counter #(.CW(CW)) u_cnt1 (
    .clk_i      (clk),
    .reset_i    (reset),
    .tick_i     (tick),
    .load_we_i  (wr_c1),
    .load_val_i (wdata),
    .ctrl_we_i  (wr_ctrl),
    .en_i       (wdata[CTRL_C1_EN]),
    .auto_i     (wdata[CTRL_C1_AUTO]),
    .load_o     (c1_load),
    .count_o    (c1_count),
    .en_o       (c1_en),
    .auto_o     (c1_auto),
    .pulse_o    (c1_pulse)
  );

  always_comb begin
    interrupts           = '0;
    interrupts[IRQ_IO0]  = io_pulse_q[0];
    interrupts[IRQ_IO1]  = io_pulse_q[1];
    interrupts[IRQ_CNT0] = c0_pulse;
    interrupts[IRQ_CNT1] = c1_pulse;
  end

  always_comb begin
    rdata = '0;
    case (reg_idx_e'(addr))
      REG_CTRL: begin
        rdata[CTRL_C0_EN]              = c0_en;
        rdata[CTRL_C0_AUTO]            = c0_auto;
        rdata[CTRL_C1_EN]              = c1_en;
        rdata[CTRL_C1_AUTO]            = c1_auto;
        rdata[CTRL_IO_EN_LSB +: 2]     = io_en_q;
      end
      REG_C0_LOAD:  rdata = c0_load;
      REG_C1_LOAD:  rdata = c1_load;
      REG_C0_COUNT: rdata = c0_count;
      REG_C1_COUNT: rdata = c1_count;
      REG_STATUS:   rdata[7:0] = {interrupt_taken, status_q};
`ifdef INT_GEN_PRESCALE_EN
      REG_PRESCALE: rdata[7:0] = prescale_q;
`endif
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_gen.sv
// Self-checking bench for int_gen: register vector table plus timed sequences
// for IO edges, counters, STATUS clear races and reset behaviour.
module tb_int_gen;

  localparam int unsigned CW = 32;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    io_irq = '0;
  logic          we = 1'b0;
  logic [2:0]    addr = '0;
  logic [CW-1:0] wdata = '0;
  logic [CW-1:0] rdata;
  logic [3:0]    interrupts;
  logic [3:0]    interrupt_taken = '0;

  int_gen #(.SYNC_STAGES(SS), .CW(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .io_irq          (io_irq),
    .we              (we),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .interrupts      (interrupts),
    .interrupt_taken (interrupt_taken)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle stamps of every observed pulse, per interrupt line.
  int pt0[$], pt1[$], pt2[$], pt3[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (interrupts[0]) pt0.push_back(cyc);
      if (interrupts[1]) pt1.push_back(cyc);
      if (interrupts[2]) pt2.push_back(cyc);
      if (interrupts[3]) pt3.push_back(cyc);
    end
  end

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          we;
    logic [2:0]  wa;
    logic [31:0] d;
    logic [3:0]  taken;
    logic [2:0]  ra;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic expect_val(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] act);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got 0x%0h, nothing expected", act);
      return;
    end
    e = sb.pop_front();
    if (act !== e.val) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", e.name, act, e.val);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    expect_val(name, exp);
    compare(act);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input bit w, input logic [2:0] wa, input logic [31:0] d,
                              input logic [3:0] tk, input logic [2:0] ra,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.we = w; v.wa = wa; v.d = d; v.taken = tk; v.ra = ra; v.exp = exp; v.name = name;
    vt.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int e, c0;
    logic [31:0] pre_exp;

`ifdef INT_GEN_PRESCALE_EN
    pre_exp = 32'h55;
`else
    pre_exp = 32'h0;
`endif
    add(0, 0, 0,            4'h0, 3'd0, 32'h0,        "rst_ctrl");
    add(0, 0, 0,            4'h0, 3'd1, 32'h0,        "rst_c0_load");
    add(0, 0, 0,            4'h0, 3'd2, 32'h0,        "rst_c1_load");
    add(0, 0, 0,            4'h0, 3'd3, 32'h0,        "rst_c0_count");
    add(0, 0, 0,            4'h0, 3'd4, 32'h0,        "rst_c1_count");
    add(0, 0, 0,            4'h0, 3'd5, 32'h0,        "rst_status");
    add(0, 0, 0,            4'h0, 3'd6, 32'h0,        "rst_prescale");
    add(0, 0, 0,            4'h0, 3'd7, 32'h0,        "rst_addr7");
    add(0, 0, 0,            4'hA, 3'd5, 32'hA0,       "status_taken_mirror");
    add(1, 0, 32'hFFFFFFFA, 4'h0, 3'd0, 32'h3A,       "ctrl_mask");
    add(1, 1, 32'h12345678, 4'h0, 3'd1, 32'h12345678, "c0_load_rd");
    add(0, 0, 0,            4'h0, 3'd3, 32'h12345678, "c0_count_loaded");
    add(1, 2, 32'h0000CAFE, 4'h0, 3'd4, 32'h0000CAFE, "c1_count_loaded");
    add(1, 6, 32'h00000055, 4'h0, 3'd6, pre_exp,      "prescale_rd");
    add(1, 7, 32'hFFFFFFFF, 4'h0, 3'd7, 32'h0,        "addr7_ignored");
    add(1, 0, 32'h0,        4'h0, 3'd0, 32'h0,        "ctrl_clear");
    add(1, 1, 32'h0,        4'h0, 3'd3, 32'h0,        "c0_zero");
    add(1, 2, 32'h0,        4'h0, 3'd4, 32'h0,        "c1_zero");
    add(1, 6, 32'h0,        4'h0, 3'd6, 32'h0,        "prescale_zero");

    step(3);
    check("irq_during_reset", interrupts, 4'h0);
    reset = 1'b0;
    step(1);

    foreach (vt[i]) begin
      interrupt_taken = vt[i].taken;
      if (vt[i].we) wr(vt[i].wa, vt[i].d);
      addr = vt[i].ra;
      expect_val(vt[i].name, vt[i].exp);
      #1;
      compare(rdata);
      step(1);
    end
    interrupt_taken = '0;

    // IO0 rising edge: one pulse SS+1 edges after the change, held line stays quiet
    wr(0, 32'h10);
    pt0.delete(); pt1.delete();
    c0 = cyc;
    io_irq[0] = 1'b1;
    step(12);
    check("io0_pulse_count", pt0.size(), 1);
    check("io0_pulse_cycle", (pt0.size() > 0) ? pt0[0] : -1, c0 + 1 + SS);
    rd(5, v);
    check("status_io0", v, 32'h1);
    io_irq[1] = 1'b1;
    step(8);
    check("io1_gated_off", pt1.size(), 0);

    // STATUS clear racing a fresh io1 pulse: set wins
    io_irq[1] = 1'b0;
    wr(0, 32'h30);
    step(5);
    io_irq[1] = 1'b1;
    step(SS + 1);
    check("io1_pulse_visible", interrupts, 4'b0010);
    wr(5, 32'hF);
    rd(5, v);
    check("status_clear_race", v, 32'h2);
    check("io0_held_single", pt0.size(), 1);
    wr(5, 32'hF);
    rd(5, v);
    check("status_cleared", v, 32'h0);
    io_irq = '0;

    // Counter 0 auto-reload with LOAD=3: period 4
    wr(0, 32'h0);
    wr(1, 32'd3);
    pt2.delete();
    wr(0, 32'h3);
    e = cyc;
    step(18);
    wr(0, 32'h0);
    step(2);
    check("c0_auto_count", pt2.size(), 4);
    for (int j = 0; j < 4 && j < pt2.size(); j++)
      check("c0_auto_cycle", pt2[j], e + 4 * (j + 1));

    // One-shot: single pulse then c0_en clears
    wr(1, 32'd3);
    pt2.delete();
    wr(0, 32'h1);
    e = cyc;
    step(12);
    check("c0_oneshot_count", pt2.size(), 1);
    check("c0_oneshot_cycle", (pt2.size() > 0) ? pt2[0] : -1, e + 4);
    rd(0, v);
    check("c0_en_cleared", v, 32'h0);
    rd(3, v);
    check("c0_count_zero", v, 32'h0);

    // LOAD=0 with auto: a pulse on every tick
    wr(1, 32'd0);
    pt2.delete();
    wr(0, 32'h3);
    e = cyc;
    step(5);
    wr(0, 32'h0);
    step(2);
    check("c0_load0_count", pt2.size(), 6);
    for (int j = 0; j < 6 && j < pt2.size(); j++)
      check("c0_load0_cycle", pt2[j], e + 1 + j);

    // C1_LOAD write on the terminal tick: pulse kept, written value wins
    step(2);
    wr(5, 32'hF);
    wr(2, 32'd2);
    pt3.delete();
    wr(0, 32'h4);
    e = cyc;
    step(2);
    wr(2, 32'd5);
    rd(4, v);
    check("c1_count_after_race", v, 32'd5);
    check("c1_race_pulse_count", pt3.size(), 1);
    check("c1_race_pulse_cycle", (pt3.size() > 0) ? pt3[0] : -1, e + 3);
    rd(0, v);
    check("c1_en_cleared", v, 32'h0);
    step(6);
    rd(4, v);
    check("c1_count_held", v, 32'd5);
    rd(5, v);
    check("status_c1", v, 32'h8);

    // Reset mid-countdown with count=2; io0 held high across reset
    wr(1, 32'd2);
    wr(0, 32'h1);
    io_irq[0] = 1'b1;
    reset = 1'b1;
    pt0.delete(); pt2.delete();
    step(3);
    check("irq_in_reset", interrupts, 4'h0);
    reset = 1'b0;
    rd(0, v); check("post_rst_ctrl", v, 32'h0);
    rd(1, v); check("post_rst_c0_load", v, 32'h0);
    rd(3, v); check("post_rst_c0_count", v, 32'h0);
    rd(5, v); check("post_rst_status", v, 32'h0);
    wr(0, 32'h10);
    step(8);
    check("no_c0_pulse_after_reset", pt2.size(), 0);
    check("held_io0_no_pulse", pt0.size(), 0);
    io_irq[0] = 1'b0;
    step(5);
    c0 = cyc;
    io_irq[0] = 1'b1;
    step(8);
    check("io0_rearm_count", pt0.size(), 1);
    check("io0_rearm_cycle", (pt0.size() > 0) ? pt0[0] : -1, c0 + 1 + SS);
    io_irq = '0;

`ifdef INT_GEN_PRESCALE_EN
    // PRESCALE=3, LOAD=1, auto: one pulse every 8 cycles
    wr(0, 32'h0);
    wr(6, 32'd3);
    wr(1, 32'd1);
    pt2.delete();
    wr(0, 32'h3);
    step(40);
    wr(0, 32'h0);
    check("prescale_pulses", pt2.size() >= 4, 1);
    for (int j = 1; j < pt2.size(); j++)
      check("prescale_period", pt2[j] - pt2[j-1], 8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_gen.md
INT_GEN -- requirements
Module: int_gen

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for the asynchronous IO lines.
REQ-002 SHALL have parameter CW, default 32, meaning counter and register width.
REQ-003 SHALL have one clock and a synchronous active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 io_irq  in  2  asynchronous IO interrupt lines, active high.
REQ-007 we  in  1  register write strobe.
REQ-008 addr  in  3  word register index.
REQ-009 wdata  in  CW  write data.
REQ-010 rdata  out  CW  read data, combinational on addr.
REQ-011 interrupts  out  4  single-cycle request pulses to the fetch stage: [0] io0, [1] io1, [2] counter0, [3] counter1.
REQ-012 interrupt_taken  in  4  one-hot handler-in-service indication from the fetch stage.

Function
REQ-013 Register map SHALL be: 0 CTRL, 1 C0_LOAD, 2 C1_LOAD, 3 C0_COUNT (read-only), 4 C1_COUNT (read-only), 5 STATUS (write-1-to-clear), 6 PRESCALE (macro only), 7 reads 0.
REQ-014 CTRL bits SHALL be: [0] c0_en, [1] c0_auto, [2] c1_en, [3] c1_auto, [5:4] io_en; other bits read 0.
REQ-015 Each io_irq line SHALL pass through SYNC_STAGES flops, then a registered rising-edge detector.
REQ-016 With SYNC_STAGES=2, a rising edge first sampled high at edge k SHALL drive interrupts[i] high for exactly the cycle after edge k+2, gated by io_en[i].
REQ-017 A held-high io_irq SHALL produce exactly one pulse.
REQ-018 Writing Cx_LOAD SHALL set both the load and count registers of counter x on the next edge.
REQ-019 When cx_en=1 and count!=0, count SHALL decrement by 1 per tick; a tick is every cycle without the macro.
REQ-020 When cx_en=1 and count==0 on a tick, the block SHALL pulse interrupts[2+x] for one cycle and then:
- reload count from load if cx_auto=1;
- otherwise clear cx_en.
REQ-021 With load=0 and auto=1, the counter SHALL pulse on every tick.
REQ-022 If a Cx_LOAD write coincides with a terminal tick, the pulse SHALL still be issued and the written value SHALL take precedence for count.
REQ-023 Any interrupts pulse SHALL set the matching STATUS[3:0] pending bit.
REQ-024 STATUS[7:4] SHALL mirror interrupt_taken.
REQ-025 If a write-1-to-clear coincides with a new event on the same STATUS bit, set SHALL win.
REQ-026 All interrupts outputs SHALL be registered, with no combinational path from any input.

Reset
REQ-027 During reset, interrupts SHALL be 0 and CTRL, both load/count registers, STATUS, the synchronizers and the edge detectors SHALL be 0.
REQ-028 Reset asserted mid-countdown SHALL abort it with no pulse.
REQ-029 After reset deassertion, an io_irq line already high SHALL NOT produce a pulse until it falls and rises again.

Configuration
REQ-030 Macro INT_GEN_PRESCALE_EN SHALL, when defined, add an 8-bit PRESCALE register (reset 0) and a free-running prescale counter.
REQ-031 With the macro defined, a tick SHALL occur once every PRESCALE+1 cycles, shared by both counters.
REQ-032 With the macro undefined, the tick SHALL be constant 1, addr 6 SHALL read 0, and writes to addr 6 SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold:
- register index constants;
- CTRL bit positions;
- interrupt index constants (IO0=0, IO1=1, CNT0=2, CNT1=3).
REQ-034 The block SHALL use one sub-module, int_counter, instantiated twice, holding load/count/en/auto state and the terminal pulse.

Verification
REQ-035 io_irq[0] rising at cycle 10 with io_en=01 -> interrupts=0001 for exactly one cycle at cycle 13, STATUS=0x1; io_irq held high -> no further pulse.
REQ-036 C0_LOAD=3, CTRL=0x3 -> interrupts[2] pulses every 4 cycles; CTRL=0x1 -> one pulse, then c0_en reads 0.
REQ-037 C1_LOAD written on the terminal cycle with value 5 -> pulse is issued, C1_COUNT reads 5 next cycle.
REQ-038 STATUS write 0xF coinciding with an io1 pulse -> STATUS reads 0x2 afterwards.
REQ-039 Reset asserted with count=2 -> no pulse, all registers 0, interrupts=0000.
REQ-040 With INT_GEN_PRESCALE_EN, PRESCALE=3, C0_LOAD=1, auto -> pulses every 8 cycles; without the macro, addr 6 reads 0.
